// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared arbiter state encoding and gate source indices for the datapath bus
package bus_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_TURN} arb_state_t;
  localparam int GATE_PC     = 0;
  localparam int GATE_MDR    = 1;
  localparam int GATE_ALU    = 2;
  localparam int GATE_MARMUX = 3;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority search, first set req at or above rr_ptr (wrapping) wins
module rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr_ptr,
  output logic         any_req,
  output logic [W-1:0] winner_idx
);
  logic [W:0] k;
  always_comb begin
    any_req = 1'b0;
    winner_idx = '0;
    k = '0;
    // scan highest offset first so the nearest-to-pointer hit is assigned last
    for (int i = N - 1; i >= 0; i--) begin
      k = {1'b0, rr_ptr} + (W + 1)'(i);
      k = (k >= (W + 1)'(N)) ? k - (W + 1)'(N) : k;
      if (req[k[W-1:0]]) begin
        any_req = 1'b1;
        winner_idx = k[W-1:0];
      end
    end
  end
endmodule

// File: rtl/bus_gate_arbiter.sv
// bus_gate_arbiter: round-robin owner of the one-hot gated bus with registered gate,
// one-cycle turnaround between owners and a hold timeout that forces a revoke
module bus_gate_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N_SRC    = 4,
  parameter int MAX_HOLD = 16,
  parameter int IDX_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_SRC-1:0] req,
  input  logic             clr_err,
  output logic [N_SRC-1:0] gate_oh,
  output logic [IDX_W-1:0] owner_idx,
  output logic             busy,
  output logic             timeout_err
);
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  arb_state_t state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d, winner_idx;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_SRC-1:0] gate_q, gate_d;
  logic busy_q, busy_d, err_q, err_d;
  logic any_req, arb, take, own_req, expire;

  rr_pick #(.N(N_SRC), .W(IDX_W)) u_pick (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .any_req   (any_req),
    .winner_idx(winner_idx)
  );

  assign arb     = state_q != ARB_GRANT;
  assign take    = arb && any_req;
  assign own_req = req[owner_q];
  assign expire  = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      hold_q   <= '0;
      gate_q   <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
      gate_q   <= gate_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = arb ? (any_req ? ARB_GRANT : ARB_IDLE)
                  : ((own_req && !expire) ? ARB_GRANT : ARB_TURN);
  end

  // outputs are computed one cycle ahead so gate_oh comes straight from flops
  always_comb begin
    owner_d  = take ? winner_idx : owner_q;
    rr_ptr_d = take ? ((winner_idx == IDX_W'(N_SRC - 1)) ? '0 : winner_idx + 1'b1) : rr_ptr_q;
    hold_d   = arb ? '0 : hold_q + 1'b1;
    gate_d   = (state_d == ARB_GRANT) ? (N_SRC'(1) << owner_d) : '0;
    busy_d   = state_d == ARB_GRANT;
    err_d    = (!arb && own_req && expire) || (err_q && !clr_err);
  end

  assign gate_oh     = gate_q;
  assign owner_idx   = owner_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;
endmodule

// File: tb/tb_bus_gate_arbiter.sv
// tb_bus_gate_arbiter: directed vectors with hand-computed expectations for the bus gate arbiter
module tb_bus_gate_arbiter;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic [3:0] req = '0;
  logic clr_err = 1'b0;
  logic [3:0] gate_oh;
  logic [1:0] owner_idx;
  logic busy, timeout_err;
  int total = 0;
  int bad = 0;

  bus_gate_arbiter #(.N_SRC(4), .MAX_HOLD(16)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req        (req),
    .clr_err    (clr_err),
    .gate_oh    (gate_oh),
    .owner_idx  (owner_idx),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    #2 Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  task automatic gate_is(input string tag, input logic [3:0] g);
    chk({tag, ".gate"}, 32'(gate_oh), 32'(g));
    chk({tag, ".busy"}, 32'(busy), 32'(g != 4'b0));
  endtask

  always @(negedge Clk) begin
    chk("inv.onehot0", 32'($onehot0(gate_oh)), 32'd1);
    chk("inv.busy", 32'(busy), 32'(|gate_oh));
    chk("inv.owner", 32'(gate_oh[owner_idx]), 32'(busy));
  end

  initial begin
    @(posedge Clk);
    #1;
    chk("rst.gate", 32'(gate_oh), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.owner", 32'(owner_idx), 32'h0);
    chk("rst.err", 32'(timeout_err), 32'h0);
    Reset = 1'b0;

    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step();
      gate_is("single", 4'b0100);
      chk("single.owner", 32'(owner_idx), 32'd2);
    end
    req = 4'b0000;
    step();
    gate_is("single.turn", 4'b0000);
    step();
    gate_is("single.idle", 4'b0000);

    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      gate_is("rr.g1", 4'b0001 << (k % 4));
      chk("rr.owner", 32'(owner_idx), 32'(k % 4));
      step();
      gate_is("rr.g2", 4'b0001 << (k % 4));
      req = 4'b1111 & ~(4'b0001 << (k % 4));
      step();
      gate_is("rr.turn", 4'b0000);
      req = 4'b1111;
    end

    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 16; i++) begin
      step();
      gate_is("to.hold", 4'b0010);
      chk("to.err0", 32'(timeout_err), 32'h0);
    end
    step();
    gate_is("to.revoke", 4'b0000);
    chk("to.err1", 32'(timeout_err), 32'h1);
    step();
    gate_is("to.regrant", 4'b0010);
    chk("to.sticky", 32'(timeout_err), 32'h1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("to.clr", 32'(timeout_err), 32'h0);
    req = 4'b0000;
    step();
    gate_is("to.rel", 4'b0000);

    do_reset();
    req = 4'b1001;
    step();
    gate_is("fair.first", 4'b0001);
    chk("fair.owner0", 32'(owner_idx), 32'd0);
    req = 4'b1000;
    step();
    gate_is("fair.turn", 4'b0000);
    req = 4'b1001;
    step();
    gate_is("fair.second", 4'b1000);
    chk("fair.owner3", 32'(owner_idx), 32'd3);

    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 18; i++) step();
    gate_is("arst.pre", 4'b0010);
    chk("arst.pre_err", 32'(timeout_err), 32'h1);
    #3 Reset = 1'b1;
    #1;
    gate_is("arst.now", 4'b0000);
    chk("arst.err", 32'(timeout_err), 32'h0);
    req = 4'b1001;
    @(posedge Clk);
    #1 Reset = 1'b0;
    step();
    gate_is("arst.win", 4'b0001);
    chk("arst.owner", 32'(owner_idx), 32'd0);

    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 16; i++) step();
    gate_is("race.hold", 4'b0010);
    req = 4'b0000;
    step();
    gate_is("race.turn", 4'b0000);
    chk("race.err", 32'(timeout_err), 32'h0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_gate_arbiter.md
Name: bus_gate_arbiter

Overview:
- Sequential control end of the one-hot gated datapath bus.
- The 4:1 one-hot bus mux consumes a gate select; this block produces it.
- Arbitrates N_SRC bus drivers (PC, MDR, ALU, MARMUX) with round-robin fairness, a registered one-hot gate, a mandatory turnaround cycle and a hold timeout.
- The gate output never has more than one bit set, so the bus mux default (all-zero) path is used only when idle.

Parameters:
N_SRC, 4, number of bus sources; width of req and gate_oh
MAX_HOLD, 16, max consecutive GRANT cycles before forced revoke; 0 disables timeout
IDX_W, $clog2(N_SRC), width of owner index

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
req  input  N_SRC  per-source bus request; level, held while the source uses the bus
clr_err  input  1  synchronous clear of timeout_err
gate_oh  output  N_SRC  registered one-hot gate select to the bus mux; all-zero = bus undriven
owner_idx  output  IDX_W  binary index of current owner; valid only while busy=1
busy  output  1  registered; high exactly when gate_oh != 0
timeout_err  output  1  sticky; set on forced revoke

Behaviour:
- Reset (async assert, sync deassert by system): state=IDLE, gate_oh=0, owner_idx=0, busy=0, timeout_err=0, rr_ptr=0, hold_cnt=0.
- Reset mid-grant drops gate_oh in the same instant, without waiting for a clock edge.
- States:
  - IDLE: gate_oh=0.
  - GRANT: gate_oh=onehot(owner).
  - TURN: gate_oh=0, exactly one cycle.
- Arbitration, evaluated in IDLE and TURN:
  - Search req from index rr_ptr upward, wrapping modulo N_SRC; the first set bit wins.
  - The winner is registered at the next edge: gate_oh, owner_idx and busy update together. Latency req-to-gate is 1 cycle.
  - On grant, rr_ptr <= (winner+1) mod N_SRC.
- GRANT:
  - While req[owner]=1 and timeout has not expired, hold the grant. Other requests are ignored; there is no preemption.
  - If req[owner]=0 is sampled, next state is TURN.
  - From release sample to next possible grant is 2 edges, which guarantees a 1-cycle undriven bus.
- Timeout:
  - hold_cnt clears on entry to GRANT and increments each GRANT cycle.
  - If MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 with req[owner] still 1, then the next state is TURN and timeout_err is set.
  - The revoked source may still be requesting; it competes again at lowest priority because rr_ptr has already advanced.
- Simultaneous timeout-set and clr_err in the same cycle: set wins.
- Release and timeout expiring in the same cycle: treated as a normal release; timeout_err is not set.
- gate_oh is driven from flops only, never from comb logic on req, so the bus mux select is glitch-free.
- Invariants:
  - $onehot0(gate_oh) always holds.
  - busy == |gate_oh.
  - gate_oh[owner_idx] == busy.
- N_SRC=1 is legal. With one source, rr_ptr stays 0, and TURN still separates back-to-back grants to the same source.

Decomposition:
- Package bus_arb_pkg holds:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_TURN} arb_state_t
  - localparam gate source indices GATE_PC=0, GATE_MDR=1, GATE_ALU=2, GATE_MARMUX=3
- One sub-module, rr_pick: combinational rotate-priority search.
  - Inputs: req, rr_ptr.
  - Outputs: any_req, winner_idx.
  - Reusable for the future memory-port arbiter.
- FSM, counter and output flops stay in the top module.

Test Plan:
- Reset then req=4'b0100 held 3 cycles, then dropped:
  - gate_oh=0100 and owner_idx=2 one edge after req.
  - gate_oh=0000 one edge after the drop, for exactly one cycle.
  - busy tracks gate_oh throughout.
- req=4'b1111 held constantly, each owner dropping req for one cycle after 2 granted cycles and then re-raising:
  - Grant order is 0,1,2,3,0.
  - Exactly one zero gate cycle between grants.
  - gate_oh is never multi-hot.
- MAX_HOLD=16, req=4'b0010 held forever:
  - gate_oh=0010 for 16 cycles, then 0000 for one cycle.
  - timeout_err=1, sticky.
  - Next grant is 0010 again (only requester).
  - clr_err=1 for one cycle -> timeout_err=0.
- req=4'b1001 with rr_ptr=0:
  - Grant source 0; after release, source 3 wins even though source 0 re-requests.
- Reset asserted asynchronously mid-GRANT (between edges):
  - gate_oh, busy and timeout_err are 0 immediately.
  - After Reset deasserts, with req=4'b1000 and 4'b0001 both pending, source 0 wins (rr_ptr=0).
- Release and timeout on the same cycle (owner drops req at hold_cnt=MAX_HOLD-1):
  - TURN entered, timeout_err stays 0.
